// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one external ALU: IDLE -> EXEC -> RESP.
// Define ALU_ARBITER_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [4:0]       func0,
    input  logic [4:0]       func1,
    input  logic             alu_op0,
    input  logic             alu_op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [4:0]       alu_func,
    output logic             alu_op_o,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid0,
    output logic             rsp_valid1,
    output logic [WIDTH-1:0] rsp_data
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             win_q;
    logic             pick;
    logic             take;
    logic [4:0]       func_q;
    logic             op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] data_q;

    // req levels only matter outside EXEC
    assign take = (state_q != EXEC) && (req0 || req1);

`ifdef ALU_ARBITER_FIXED_PRIO_EN
    assign pick = !req0;
`else
    logic last_q;

    assign pick = (req0 && req1) ? !last_q : req1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (take) begin
            last_q <= pick;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            func_q  <= '0;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                win_q  <= pick;
                func_q <= pick ? func1 : func0;
                op_q   <= pick ? alu_op1 : alu_op0;
                a_q    <= pick ? a1 : a0;
                b_q    <= pick ? b1 : b0;
            end
            if (state_q == EXEC) begin
                data_q <= alu_result;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        rsp_valid0 = 1'b0;
        rsp_valid1 = 1'b0;
        alu_func   = '0;
        alu_op_o   = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        unique case (state_q)
            IDLE: begin
                if (take) state_d = EXEC;
            end
            EXEC: begin
                state_d  = RESP;
                gnt0     = !win_q;
                gnt1     = win_q;
                alu_func = func_q;
                alu_op_o = op_q;
                alu_a    = a_q;
                alu_b    = b_q;
            end
            RESP: begin
                state_d    = take ? EXEC : IDLE;
                rsp_valid0 = !win_q;
                rsp_valid1 = win_q;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_data = data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural shared ALU.
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 1'b0;
    logic         req1 = 1'b0;
    logic [4:0]   func0 = '0;
    logic [4:0]   func1 = '0;
    logic         alu_op0 = 1'b0;
    logic         alu_op1 = 1'b0;
    logic [W-1:0] a0 = '0;
    logic [W-1:0] b0 = '0;
    logic [W-1:0] a1 = '0;
    logic [W-1:0] b1 = '0;
    logic         gnt0;
    logic         gnt1;
    logic [4:0]   alu_func;
    logic         alu_op_o;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_result;
    logic         rsp_valid0;
    logic         rsp_valid1;
    logic [W-1:0] rsp_data;

    int tests = 0;
    int fails = 0;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .func0(func0), .func1(func1),
        .alu_op0(alu_op0), .alu_op1(alu_op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .alu_func(alu_func), .alu_op_o(alu_op_o),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result),
        .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_result = '0;
        if (!alu_op_o) begin
            alu_result = alu_a + alu_b;
        end else begin
            case (alu_func)
                5'd1: alu_result = alu_a + alu_b;
                5'd2: alu_result = alu_a & alu_b;
                5'd3: alu_result = ~alu_a;
                5'd4: alu_result = alu_a ^ alu_b;
                5'd5: alu_result = alu_a << alu_b[4:0];
                5'd6: alu_result = alu_a >> alu_b[4:0];
                5'd7: alu_result = $signed(alu_a) >>> alu_b[4:0];
                5'd8: alu_result = alu_a - alu_b;
                default: alu_result = '0;
            endcase
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests++;
        if ({gnt0, gnt1, rsp_valid0, rsp_valid1} !== 4'b0) begin
            fails++;
            $display("FAIL reset_strobes got=%b want=0000",
                     {gnt0, gnt1, rsp_valid0, rsp_valid1});
        end
        tests++;
        if ({alu_func, alu_op_o, alu_a, alu_b, rsp_data} !== '0) begin
            fails++;
            $display("FAIL reset_data func=%0d a=%0d b=%0d rsp=%0d want 0",
                     alu_func, alu_a, alu_b, rsp_data);
        end
    endtask

    task automatic test_single_op();
        @(negedge clk);
        req0 = 1'b1; alu_op0 = 1'b1; func0 = 5'd1; a0 = 5; b0 = 7;
        @(posedge clk);
        #1 req0 = 1'b0;
        @(negedge clk);
        tests++;
        if ({gnt0, gnt1, rsp_valid0} !== 3'b100) begin
            fails++;
            $display("FAIL single_gnt got=%b want=100", {gnt0, gnt1, rsp_valid0});
        end
        tests++;
        if (alu_func !== 5'd1 || alu_op_o !== 1'b1 || alu_a !== 5 || alu_b !== 7) begin
            fails++;
            $display("FAIL single_alu func=%0d op=%0d a=%0d b=%0d want 1 1 5 7",
                     alu_func, alu_op_o, alu_a, alu_b);
        end
        @(negedge clk);
        tests++;
        if ({gnt0, rsp_valid0, rsp_valid1} !== 3'b010 || rsp_data !== 12) begin
            fails++;
            $display("FAIL single_rsp got=%b data=%0d want=010 data=12",
                     {gnt0, rsp_valid0, rsp_valid1}, rsp_data);
        end
        @(negedge clk);
        tests++;
        if (rsp_valid0 !== 1'b0 || rsp_data !== 12 || alu_a !== '0) begin
            fails++;
            $display("FAIL single_idle vld=%b data=%0d a=%0d want 0 12 0",
                     rsp_valid0, rsp_data, alu_a);
        end
    endtask

    task automatic test_forced_add();
        @(negedge clk);
        req1 = 1'b1; alu_op1 = 1'b0; func1 = 5'd4; a1 = 3; b1 = 9;
        @(posedge clk);
        #1 req1 = 1'b0;
        @(negedge clk);
        tests++;
        if ({gnt0, gnt1} !== 2'b01 || alu_op_o !== 1'b0 || alu_func !== 5'd4) begin
            fails++;
            $display("FAIL forced_exec gnt=%b op=%0d func=%0d want 01 0 4",
                     {gnt0, gnt1}, alu_op_o, alu_func);
        end
        @(negedge clk);
        tests++;
        if ({rsp_valid0, rsp_valid1} !== 2'b01 || rsp_data !== 12) begin
            fails++;
            $display("FAIL forced_rsp vld=%b data=%0d want 01 12",
                     {rsp_valid0, rsp_valid1}, rsp_data);
        end
    endtask

    task automatic test_undef_func();
        @(negedge clk);
        req1 = 1'b1; alu_op1 = 1'b1; func1 = 5'd31; a1 = 100; b1 = 1;
        @(posedge clk);
        #1 req1 = 1'b0;
        @(negedge clk);
        tests++;
        if (gnt1 !== 1'b1 || alu_func !== 5'd31 || alu_a !== 100) begin
            fails++;
            $display("FAIL undef_func gnt1=%b func=%0d a=%0d want 1 31 100",
                     gnt1, alu_func, alu_a);
        end
        @(negedge clk);
        tests++;
        if (rsp_valid1 !== 1'b1 || rsp_data !== 0) begin
            fails++;
            $display("FAIL undef_rsp vld=%b data=%0d want 1 0", rsp_valid1, rsp_data);
        end
    endtask

    task automatic test_tie();
        logic [3:0] want;
`ifdef ALU_ARBITER_FIXED_PRIO_EN
        want = 4'b0000;
`else
        want = 4'b1010;
`endif
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        alu_op0 = 1'b1; func0 = 5'd8; a0 = 50; b0 = 8;
        alu_op1 = 1'b1; func1 = 5'd2; a1 = 12; b1 = 10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (gnt0 !== !want[i] || gnt1 !== want[i]) begin
                fails++;
                $display("FAIL tie_gnt%0d got=%b%b want winner=%0d",
                         i, gnt0, gnt1, want[i]);
            end
            @(negedge clk);
            tests++;
            if (rsp_valid1 !== want[i] || rsp_data !== (want[i] ? 32'd8 : 32'd42)) begin
                fails++;
                $display("FAIL tie_rsp%0d vld1=%b data=%0d want %0d",
                         i, rsp_valid1, rsp_data, want[i]);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req0 = 1'b1; alu_op0 = 1'b1; func0 = 5'd5; a0 = 3; b0 = 4;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests++;
            if (gnt0 !== (i % 2 == 0) || rsp_valid0 !== (i % 2 == 1)
                || (rsp_valid0 && rsp_data !== 48)) begin
                fails++;
                $display("FAIL b2b_cyc%0d gnt0=%b vld0=%b data=%0d",
                         i, gnt0, rsp_valid0, rsp_data);
            end
        end
        req0 = 1'b0;
        @(negedge clk);
        tests++;
        if ({gnt0, gnt1, rsp_valid0, rsp_valid1} !== 4'b0) begin
            fails++;
            $display("FAIL b2b_idle got=%b want=0000",
                     {gnt0, gnt1, rsp_valid0, rsp_valid1});
        end
    endtask

    task automatic test_reset_mid_exec();
        int seen;
        @(negedge clk);
        req0 = 1'b1; alu_op0 = 1'b1; func0 = 5'd4; a0 = 9; b0 = 6;
        @(posedge clk);
        #1 req0 = 1'b0;
        @(negedge clk);
        tests++;
        if (gnt0 !== 1'b1) begin
            fails++;
            $display("FAIL midrst_pre gnt0=%b want 1", gnt0);
        end
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({gnt0, gnt1, rsp_valid0, rsp_valid1, alu_func, alu_op_o,
             alu_a, alu_b, rsp_data} !== '0) begin
            fails++;
            $display("FAIL midrst_out gnt=%b%b vld=%b%b func=%0d a=%0d rsp=%0d want 0",
                     gnt0, gnt1, rsp_valid0, rsp_valid1, alu_func, alu_a, rsp_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1 || rsp_valid0 || rsp_valid1) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL midrst_after strobes_seen=%0d want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_forced_add();
        test_undef_func();
        test_tie();
        test_back_to_back();
        test_reset_mid_exec();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
